fetch_buffer_unit: RTL and testbench

- Next-generation instruction fetch stage for the single-cycle/pipelined RISC-V core.
- Owns the fetch PC and issues pipelined, in-order requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions in a DEPTH-entry FIFO and presents the head entry, fully decoded, to the downstream stage through a valid/ready handshake.
- Supports redirect/flush from branch/jump resolution and carries memory errors with the instruction they belong to.

---
 rtl/fetch_buffer_unit.sv | 124 ++++++++++++
 tb/tb_fetch_buffer_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer_unit.sv
// fetch_buffer_unit: fetch PC owner, in-order imem requester and DEPTH-entry decoded instruction buffer
module fetch_buffer_unit #(
    parameter int XLEN = 64,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_instr_i,
    input  logic            imem_rsp_error_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [31:0]     out_instr_o,
    output logic [6:0]      out_opcode_o,
    output logic [4:0]      out_rd_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [9:0]      out_funct_o,
    output logic [2:0]      out_type_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic            out_error_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] TYPEI = 3'd0, TYPER = 3'd1, TYPES = 3'd2, TYPEB = 3'd3, TYPEU = 3'd4, TYPEJ = 3'd5;

    logic [XLEN-1:0] fetch_pc, rsp_pc;
    logic [CW-1:0]   outstanding, drop_cnt, count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            halted, mis_pend;
    logic [XLEN-1:0] q_pc [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [DEPTH-1:0] q_err;
    logic            acc, enq_rsp, enq_mis, enq, pop;
    logic [31:0]     imm32;

    assign imem_req_valid_o = rst_n_i && !halted && !mis_pend && !redirect_valid_i &&
                              (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign imem_req_addr_o = fetch_pc;
    assign acc = imem_req_valid_o && imem_req_ready_i;
    assign enq_rsp = imem_rsp_valid_i && drop_cnt == '0 && !redirect_valid_i;
    // a misaligned target reports its error only once every older response has drained
    assign enq_mis = mis_pend && outstanding == '0 && drop_cnt == '0 && !redirect_valid_i;
    assign enq = enq_rsp || enq_mis;
    assign out_valid_o = count != '0 && !redirect_valid_i;
    assign pop = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            halted <= 1'b0;
            mis_pend <= 1'b0;
            q_err <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i] <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(acc) - CW'(imem_rsp_valid_i);
            if (redirect_valid_i) begin
                fetch_pc <= redirect_pc_i;
                rsp_pc <= redirect_pc_i;
                drop_cnt <= outstanding - CW'(imem_rsp_valid_i);
                count <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                halted <= 1'b0;
                mis_pend <= redirect_pc_i[1:0] != 2'b00;
            end else begin
                if (acc) fetch_pc <= fetch_pc + XLEN'(4);
                if (imem_rsp_valid_i && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (enq) begin
                    q_pc[wr_ptr] <= enq_mis ? fetch_pc : rsp_pc;
                    q_instr[wr_ptr] <= enq_mis ? 32'h0 : imem_rsp_instr_i;
                    q_err[wr_ptr] <= enq_mis || imem_rsp_error_i;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (enq_rsp) rsp_pc <= rsp_pc + XLEN'(4);
                if (enq_mis || (enq_rsp && imem_rsp_error_i)) halted <= 1'b1;
                if (enq_mis) mis_pend <= 1'b0;
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(enq) - CW'(pop);
            end
        end
    end

    assign out_pc_o = q_pc[rd_ptr];
    assign out_instr_o = q_instr[rd_ptr];
    assign out_error_o = q_err[rd_ptr];
    assign out_opcode_o = out_instr_o[6:0];
    assign out_rd_o = out_instr_o[11:7];
    assign out_rs1_o = out_instr_o[19:15];
    assign out_rs2_o = out_instr_o[24:20];

    always_comb begin
        out_type_o = out_opcode_o == 7'b1100011 ? TYPEB :
                     out_opcode_o == 7'b0100011 ? TYPES :
                     out_opcode_o == 7'b1101111 ? TYPEJ :
                     out_opcode_o == 7'b0110011 ? TYPER :
                     (out_opcode_o == 7'b0110111 || out_opcode_o == 7'b0010111) ? TYPEU : TYPEI;
        imm32 = out_type_o == TYPES ? {{20{out_instr_o[31]}}, out_instr_o[31:25], out_instr_o[11:7]} :
                out_type_o == TYPEB ? {{19{out_instr_o[31]}}, out_instr_o[31], out_instr_o[7],
                                       out_instr_o[30:25], out_instr_o[11:8], 1'b0} :
                out_type_o == TYPEU ? {out_instr_o[31:12], 12'b0} :
                out_type_o == TYPEJ ? {{11{out_instr_o[31]}}, out_instr_o[31], out_instr_o[19:12],
                                       out_instr_o[20], out_instr_o[30:21], 1'b0} :
                out_type_o == TYPER ? 32'h0 : {{20{out_instr_o[31]}}, out_instr_o[31:20]};
        out_imm_o = {{(XLEN-32){imm32[31]}}, imm32};
        out_funct_o = out_type_o == TYPER ? {out_instr_o[31:25], out_instr_o[14:12]} : {7'd0, out_instr_o[14:12]};
    end
endmodule

// File: tb/tb_fetch_buffer_unit.sv
// tb_fetch_buffer_unit: directed scenarios with an in-order memory model and an expected-output scoreboard
module tb_fetch_buffer_unit;
    localparam logic [2:0] TYPEI = 3'd0, TYPER = 3'd1, TYPES = 3'd2, TYPEB = 3'd3, TYPEU = 3'd4, TYPEJ = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n_i, redirect_valid_i, imem_req_valid_o, imem_req_ready_i, imem_rsp_valid_i;
    logic        imem_rsp_error_i, out_valid_o, out_ready_i, out_error_o;
    logic [63:0] redirect_pc_i, imem_req_addr_o, out_pc_o, out_imm_o;
    logic [31:0] imem_rsp_instr_i, out_instr_o;
    logic [6:0]  out_opcode_o;
    logic [4:0]  out_rd_o, out_rs1_o, out_rs2_o;
    logic [9:0]  out_funct_o;
    logic [2:0]  out_type_o;

    always #5 clk = ~clk;

    fetch_buffer_unit dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_instr_i(imem_rsp_instr_i), .imem_rsp_error_i(imem_rsp_error_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
        .out_opcode_o(out_opcode_o), .out_rd_o(out_rd_o), .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o),
        .out_funct_o(out_funct_o), .out_type_o(out_type_o), .out_imm_o(out_imm_o), .out_error_o(out_error_o)
    );

    typedef struct packed {logic [63:0] pc; logic [31:0] instr; logic err;} ent_t;
    typedef struct packed {logic [63:0] pc; logic stale;} req_t;
    ent_t sb[$];
    req_t mq[$];

    int errors = 0, checks = 0;
    int req_cnt = 0, pop_cnt = 0, dec_hits = 0, err_pops = 0;
    logic rsp_en = 1'b1, want_first = 1'b0, last_valid = 1'b0, last_req = 1'b0;
    logic cur_stale = 1'b0, cur_err = 1'b0;
    logic [63:0] cur_pc = '0, first_pc = '1, err_pc = '1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_instr(input logic [63:0] pc);
        case (pc)
            64'h200: return 32'hFE010113;
            64'h204: return 32'hFE000EE3;
            64'h208: return 32'h12345037;
            default: return pc[31:0];
        endcase
    endfunction

    task automatic tick();
        ent_t e;
        req_t r;
        logic acc;
        logic [63:0] acc_addr;
        @(negedge clk);
        last_valid = out_valid_o;
        last_req = imem_req_valid_o;
        if (redirect_valid_i) begin
            chk("redir_out_valid", 64'(out_valid_o), 64'd0);
            chk("redir_req_valid", 64'(imem_req_valid_o), 64'd0);
            foreach (mq[i]) mq[i].stale = 1'b1;
            sb.delete();
            if (redirect_pc_i[1:0] != 2'b00) sb.push_back('{redirect_pc_i, 32'h0, 1'b1});
            want_first = 1'b1;
        end
        if (out_valid_o && out_ready_i) begin
            pop_cnt++;
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_pc", out_pc_o, e.pc);
                chk("out_instr", 64'(out_instr_o), 64'(e.instr));
                chk("out_error", 64'(out_error_o), 64'(e.err));
                if (e.err) err_pops++;
                if (want_first) begin
                    first_pc = out_pc_o;
                    want_first = 1'b0;
                end
                if (e.pc == 64'h200) begin
                    dec_hits++;
                    chk("addi_type", 64'(out_type_o), 64'(TYPEI));
                    chk("addi_imm", out_imm_o, 64'hFFFF_FFFF_FFFF_FFE0);
                    chk("addi_rd", 64'(out_rd_o), 64'd2);
                    chk("addi_rs1", 64'(out_rs1_o), 64'd2);
                    chk("addi_opcode", 64'(out_opcode_o), 64'h13);
                    chk("addi_funct", 64'(out_funct_o), 64'd0);
                end
                if (e.pc == 64'h204) begin
                    dec_hits++;
                    chk("beq_type", 64'(out_type_o), 64'(TYPEB));
                    chk("beq_imm", out_imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
                end
                if (e.pc == 64'h208) begin
                    dec_hits++;
                    chk("lui_type", 64'(out_type_o), 64'(TYPEU));
                    chk("lui_imm", out_imm_o, 64'h0000_0000_1234_5000);
                end
            end
        end
        if (imem_rsp_valid_i && !cur_stale && !redirect_valid_i) sb.push_back('{cur_pc, mem_instr(cur_pc), cur_err});
        acc = imem_req_valid_o && imem_req_ready_i;
        acc_addr = imem_req_addr_o;
        if (acc) req_cnt++;
        @(posedge clk);
        #1;
        if (acc) mq.push_back('{acc_addr, 1'b0});
        redirect_valid_i = 1'b0;
        if (rst_n_i && rsp_en && mq.size() != 0) begin
            r = mq.pop_front();
            cur_pc = r.pc;
            cur_stale = r.stale;
            cur_err = r.pc == err_pc;
            imem_rsp_valid_i = 1'b1;
            imem_rsp_instr_i = mem_instr(r.pc);
            imem_rsp_error_i = cur_err;
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_instr_i = '0;
            imem_rsp_error_i = 1'b0;
        end
    endtask

    task automatic redirect(input logic [63:0] pc);
        redirect_valid_i = 1'b1;
        redirect_pc_i = pc;
        tick();
    endtask

    task automatic reset_checks();
        chk("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_pc", out_pc_o, 64'd0);
        chk("rst_out_instr", 64'(out_instr_o), 64'd0);
        chk("rst_out_imm", out_imm_o, 64'd0);
        chk("rst_out_type", 64'(out_type_o), 64'd0);
        chk("rst_out_error", 64'(out_error_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i = '0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_instr_i = '0;
        imem_rsp_error_i = 1'b0;
        out_ready_i = 1'b1;
        #1;
        reset_checks();
        repeat (3) @(posedge clk);
        #1 rst_n_i = 1'b1;

        tick(); chk("first_valid_c0", 64'(last_valid), 64'd0);
        tick(); chk("first_valid_c1", 64'(last_valid), 64'd0);
        tick(); chk("first_valid_c2", 64'(last_valid), 64'd1);
        pop_cnt = 0;
        repeat (20) tick();
        chk("stream_rate", 64'(pop_cnt), 64'd20);

        out_ready_i = 1'b0;
        repeat (2) tick();
        #2 rst_n_i = 1'b0;
        #1;
        reset_checks();
        mq.delete();
        sb.delete();
        imem_rsp_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n_i = 1'b1;
        req_cnt = 0;
        repeat (10) tick();
        chk("bp_req_count", 64'(req_cnt), 64'd4);
        chk("bp_req_valid_low", 64'(last_req), 64'd0);
        out_ready_i = 1'b1;
        want_first = 1'b1;
        pop_cnt = 0;
        repeat (8) tick();
        chk("bp_first_pc", first_pc, 64'd0);
        chk("bp_delivered", 64'(pop_cnt >= 4), 64'd1);

        rsp_en = 1'b0;
        tick();
        rsp_en = 1'b1;
        tick();
        redirect(64'h100);
        repeat (12) tick();
        chk("redir_first_pc", first_pc, 64'h100);

        redirect(64'h200);
        repeat (10) tick();
        chk("decode_hits", 64'(dec_hits), 64'd3);

        err_pc = 64'h8;
        err_pops = 0;
        redirect(64'h0);
        repeat (15) tick();
        chk("err_delivered", 64'(err_pops), 64'd1);
        req_cnt = 0;
        repeat (10) tick();
        chk("halt_no_req", 64'(req_cnt), 64'd0);
        err_pc = '1;
        redirect(64'h20);
        req_cnt = 0;
        repeat (6) tick();
        chk("resume_req", 64'(req_cnt != 0), 64'd1);
        chk("resume_first_pc", first_pc, 64'h20);

        err_pops = 0;
        redirect(64'h302);
        req_cnt = 0;
        repeat (10) tick();
        chk("mis_no_req", 64'(req_cnt), 64'd0);
        chk("mis_err_entry", 64'(err_pops), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
